serial_tx_piso: RTL and testbench
=================================

Name: serial_tx_piso

Overview:
- Parallel-in, serial-out frame transmitter.
- Accepts a DATA_W-bit word over a valid/ready handshake. Drives it onto a single idle-high line as: start bit, data LSB first, optional parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Source end of the team's serial bit-line link, feeding flip-flop-based capture logic on the far side.

Parameters:
- DATA_W, 8, data word width (>=1)
- CLKS_PER_BIT, 4, clocks per serial bit (>=1; 1 legal)
- PARITY_EN, 1, 1 = insert parity bit after data, 0 = none
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- tx_data  input  DATA_W  word to send; sampled only on accept
- tx_valid  input  1  word available
- tx_ready  output  1  high only in IDLE; accept = tx_valid & tx_ready at rising clk
- tx_line  output  1  serial output, idle high, registered
- tx_busy  output  1  high from the cycle after accept until frame end
- tx_done  output  1  one-cycle pulse in the last clock of the stop bit

Behaviour:
- Reset (async, any time): tx_line=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, bit-period and bit counters=0, shift reg=0. Reset mid-frame aborts the frame and returns the line high immediately, without waiting for a clock edge.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - tx_line=1, tx_ready=1.
  - On accept: latch tx_data into shift reg, compute parity = ^tx_data ^ PARITY_ODD, go to START.
- START: tx_line=0 for CLKS_PER_BIT cycles, starting the cycle after the accept edge.
- DATA:
  - tx_line = shift_reg[0], held CLKS_PER_BIT cycles.
  - At end of each bit period: shift right, increment bit count.
  - After DATA_W bits go to PARITY or STOP.
- PARITY: tx_line = latched parity for CLKS_PER_BIT cycles.
- STOP:
  - tx_line=1 for CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle, then IDLE.
- Bit-period counter: counts 0..CLKS_PER_BIT-1; wraps to 0 at each bit boundary. Width = clog2(CLKS_PER_BIT), minimum 1.
- Frame length = CLKS_PER_BIT*(DATA_W+2+PARITY_EN) cycles, measured from the cycle after accept.
- Handshake rules:
  - tx_valid while busy: ignored, no state change.
  - tx_data changes after accept: no effect on the frame in flight.
- Back-to-back frames: IDLE lasts exactly one cycle with tx_ready=1. If tx_valid is held, the next frame's start bit begins one cycle after the IDLE cycle, i.e. one idle-high clock between stop and start.
- tx_busy = state != IDLE.
- Output glitch rule: tx_line comes straight from a flop; no combinational path from inputs to any output except none (tx_ready is decoded from the state register only).

Decomposition:
- Shared include (serial_link_defs.vh):
  - state encodings TX_IDLE=0, TX_START=1, TX_DATA=2, TX_PARITY=3, TX_STOP=4 (3-bit)
  - line idle level constant LINE_IDLE=1
  - these are shared with the matching receiver
- One natural sub-module: dff_async_rst (d, clk, rst, q; reset value parameterized). Used for the tx_line output flop and the shift-register bit cells.

Test Plan:
- Basic frame, DATA_W=8, CLKS=4, even parity: send 0xA5 -> tx_line bit sequence 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each bit held 4 clks; tx_done pulses on the 44th cycle after accept; tx_ready low throughout.
- Odd parity (PARITY_ODD=1), send 0x00 -> data bits all 0, parity bit 1, stop 1; frame 44 cycles.
- Back-to-back with tx_valid held: 0x01 then 0xFF -> exactly one idle-high cycle between the first stop and the second start bit; second frame data 1,1,1,1,1,1,1,1, parity 0.
- Handshake ignored while busy: pulse tx_valid with 0x3C in the 10th cycle of a 0x5A frame -> 0x5A frame unchanged, 0x3C never sent, tx_ready stays 0.
- Async reset mid-frame: assert rst between clock edges during the DATA state -> tx_line=1 and tx_ready=1 immediately. After release, a new 0x81 frame sends correctly.
- Edge config CLKS_PER_BIT=1, PARITY_EN=0: send 0x80 -> 10-cycle frame: 0, 0,0,0,0,0,0,0,1, 1; tx_done in cycle 10.

Source files
------------

// File: rtl/serial_tx_piso_pkg.sv
// Definitions shared by the serial bit-line transmitter and its matching receiver:
// FSM state encodings, the idle line level and a counter-width helper.
package serial_tx_piso_pkg;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

  // Width of a counter spanning 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_async_rst.sv
// Single-bit flop with asynchronous active-high reset to a parameterized value.
module dff_async_rst #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/serial_tx_piso.sv
// Parallel-in serial-out frame transmitter: start bit, data LSB first, optional
// parity, stop bit, each held CLKS_PER_BIT clocks on an idle-high registered line.
module serial_tx_piso
  import serial_tx_piso_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              line_d;
  logic              accept;
  logic              bit_end;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  assign tx_ready = (state == TX_IDLE);
  assign tx_busy  = (state != TX_IDLE);
  assign accept   = tx_valid & tx_ready;
  assign bit_end  = (clk_cnt == CNT_LAST);
  assign tx_done  = (state == TX_STOP) & bit_end;

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_d     = shift_q;
    parity_d    = parity_q;

    if (state != TX_IDLE) begin
      clk_cnt_nxt = bit_end ? '0 : clk_cnt + CNT_W'(1);
    end

    case (state)
      TX_IDLE: begin
        if (accept) begin
          state_nxt   = TX_START;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          shift_d     = tx_data;
          parity_d    = calc_parity(tx_data);
        end
      end
      TX_START: begin
        if (bit_end) state_nxt = TX_DATA;
      end
      TX_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (bit_end) state_nxt = TX_IDLE;
      end
      default: begin
        state_nxt   = TX_IDLE;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // The line level is decoded from the next state so the output flop
  // changes on the same edge as the FSM, with no decode after the flop.
  always_comb begin
    line_d = LINE_IDLE;
    case (state_nxt)
      TX_START:  line_d = 1'b0;
      TX_DATA:   line_d = shift_d[0];
      TX_PARITY: line_d = parity_q;
      default:   line_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      clk_cnt  <= clk_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      parity_q <= parity_d;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_shift
    dff_async_rst #(.RST_VAL(1'b0)) u_bit (
      .clk (clk),
      .rst (rst),
      .d   (shift_d[i]),
      .q   (shift_q[i])
    );
  end

  dff_async_rst #(.RST_VAL(LINE_IDLE)) u_line (
    .clk (clk),
    .rst (rst),
    .d   (line_d),
    .q   (tx_line)
  );

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso: three configurations (even parity, odd parity,
// one clock per bit without parity) checked against a bit-list frame model.
module tb_serial_tx_piso;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data [3];
  logic [2:0] tx_valid;
  logic [2:0] tx_ready;
  logic [2:0] tx_line;
  logic [2:0] tx_busy;
  logic [2:0] tx_done;

  int CPB  [3] = '{4, 4, 1};
  int PEN  [3] = '{1, 1, 0};
  int PODD [3] = '{0, 1, 0};

  int n_cmp = 0;
  int n_mis = 0;
  bit exp_q[$];

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_line(tx_line[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
  );

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_line(tx_line[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
  );

  serial_tx_piso #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
    .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .tx_line(tx_line[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line level for every clock of a frame, built from the bit list.
  task automatic build_frame(input int s, input logic [7:0] d);
    bit b[$];
    exp_q.delete();
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (PEN[s] != 0) b.push_back(((($countones(d) + PODD[s]) % 2) == 1));
    b.push_back(1'b1);
    foreach (b[i]) repeat (CPB[s]) exp_q.push_back(b[i]);
  endtask

  // Called at a falling edge with instance s idle. Returns at the falling
  // edge of the first cycle after the frame, which must be idle.
  task automatic send(input int s, input logic [7:0] d, input bit hold,
                      input logic [7:0] nxt, input int inj);
    int len;
    build_frame(s, d);
    len = exp_q.size();
    chk($sformatf("ready_before_%0d_%02h", s, d), tx_ready[s], 1'b1);
    tx_data[s]  = d;
    tx_valid[s] = 1'b1;
    @(negedge clk);
    if (hold) begin
      tx_data[s] = nxt;
    end else begin
      tx_valid[s] = 1'b0;
      tx_data[s]  = ~d;
    end
    for (int k = 0; k < len; k++) begin
      chk($sformatf("line_%0d_%02h_c%0d", s, d, k + 1), tx_line[s], exp_q[k]);
      chk($sformatf("busy_%0d_%02h_c%0d", s, d, k + 1), tx_busy[s], 1'b1);
      chk($sformatf("ready_%0d_%02h_c%0d", s, d, k + 1), tx_ready[s], 1'b0);
      chk($sformatf("done_%0d_%02h_c%0d", s, d, k + 1), tx_done[s], (k == len - 1));
      if (inj >= 0 && k == inj) begin
        tx_data[s]  = 8'h3C;
        tx_valid[s] = 1'b1;
      end
      if (inj >= 0 && k == inj + 1) tx_valid[s] = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("idle_line_%0d_%02h", s, d), tx_line[s], 1'b1);
    chk($sformatf("idle_ready_%0d_%02h", s, d), tx_ready[s], 1'b1);
    chk($sformatf("idle_busy_%0d_%02h", s, d), tx_busy[s], 1'b0);
    chk($sformatf("idle_done_%0d_%02h", s, d), tx_done[s], 1'b0);
  endtask

  initial begin
    int s;
    logic [7:0] d;
    rst      = 1'b1;
    tx_valid = '0;
    for (int i = 0; i < 3; i++) tx_data[i] = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_line_%0d", i), tx_line[i], 1'b1);
      chk($sformatf("rst_ready_%0d", i), tx_ready[i], 1'b1);
      chk($sformatf("rst_busy_%0d", i), tx_busy[i], 1'b0);
      chk($sformatf("rst_done_%0d", i), tx_done[i], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    send(0, 8'hA5, 1'b0, 8'h00, -1);
    repeat (2) @(negedge clk);
    send(1, 8'h00, 1'b0, 8'h00, -1);
    repeat (2) @(negedge clk);

    // Back-to-back with valid held: exactly one idle cycle between frames.
    send(0, 8'h01, 1'b1, 8'hFF, -1);
    send(0, 8'hFF, 1'b0, 8'h00, -1);
    @(negedge clk);

    // A valid pulse in the 10th cycle of a frame must be ignored.
    send(0, 8'h5A, 1'b0, 8'h00, 9);
    repeat (3) begin
      @(negedge clk);
      chk("no_3c_line", tx_line[0], 1'b1);
      chk("no_3c_busy", tx_busy[0], 1'b0);
    end

    // Asynchronous reset between edges while in the data bits.
    tx_data[0]  = 8'hC3;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_busy_pre_rst", tx_busy[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_line", tx_line[0], 1'b1);
    chk("arst_ready", tx_ready[0], 1'b1);
    chk("arst_busy", tx_busy[0], 1'b0);
    chk("arst_done", tx_done[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 8'h81, 1'b0, 8'h00, -1);
    @(negedge clk);

    send(2, 8'h80, 1'b0, 8'h00, -1);
    @(negedge clk);

    for (int n = 0; n < 10; n++) begin
      s = int'($urandom_range(0, 2));
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(s, d, 1'b0, 8'h00, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
